trap_controller: RTL and testbench
==================================

# trap_controller

Sequential trap-entry/return sequencer sitting directly downstream of the exception handler. It captures one resolved exception (cause, tval, pc, target privilege, vector) or an MRET/SRET request, drains the pipeline via a flush handshake, and commits the trap CSRs and privilege mode. It then issues a single-cycle PC redirect to fetch. It owns the architectural trap state: mepc/mcause/mtval, sepc/scause/stval, the mstatus interrupt-stack bits and the current privilege mode.

## Interface
- XLEN, 32, datapath width
- FLUSH_TIMEOUT, 15, watchdog limit in cycles (used only with TRAP_CTRL_WATCHDOG_EN)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- exc_valid  in  1  exception present this cycle
- exc_cause  in  XLEN  cause code
- exc_tval  in  XLEN  trap value
- exc_pc  in  XLEN  faulting PC
- exc_target_priv  in  2  01 = S, 11 = M
- exc_trap_vector  in  XLEN  handler address
- mret_req, sret_req  in  1 each  return instruction at commit
- flush_req  out  1  pipeline drain request
- flush_ack  in  1  pipeline drained
- redirect_valid  out  1  one-cycle fetch redirect strobe
- redirect_pc  out  XLEN  redirect target
- trap_busy  out  1  high whenever state ≠ IDLE; pipeline must stall
- priv_mode  out  2  current privilege
- csr_we  in  1, csr_addr  in  12, csr_wdata  in  XLEN  software CSR write port
- mepc, mcause, mtval, sepc, scause, stval, mstatus  out  XLEN each  CSR read values
- flush_timeout  out  1  sticky watchdog flag (tied 0 without macro)

## Operation
- States are IDLE, FLUSH, COMMIT and REDIRECT.
- **IDLE:**
  - exc_valid captures all exc_* fields and kind = TRAP, then goes to FLUSH.
  - Otherwise mret_req sets kind = MRET, else sret_req sets kind = SRET; either goes to FLUSH.
  - Priority is exc_valid > mret_req > sret_req.
- **FLUSH:** flush_req = 1. Goes to COMMIT on the cycle flush_ack is sampled high. All requests are ignored while busy.
- **COMMIT, TRAP to M (target 11):**
  - mepc ← {pc[XLEN-1:1], 0}, mcause ← cause, mtval ← tval.
  - MPIE ← MIE, MIE ← 0, MPP ← priv_mode, priv_mode ← 11.
- **COMMIT, TRAP to S (target 01):**
  - sepc, scause, stval are updated the same way as the M case.
  - SPIE ← SIE, SIE ← 0, SPP ← priv_mode[0], priv_mode ← 01.
- **COMMIT, MRET:** MIE ← MPIE, MPIE ← 1, priv_mode ← MPP, MPP ← 00. Target = mepc.
- **COMMIT, SRET:** SIE ← SPIE, SPIE ← 1, priv_mode ← {0, SPP}, SPP ← 0. Target = sepc.
- **REDIRECT:** redirect_valid = 1 for exactly one cycle, then IDLE.
  - For a trap, redirect_pc = the captured vector.
  - For a return, redirect_pc = the xepc value as it stood after COMMIT.
- **mstatus layout:** SIE[1], MIE[3], SPIE[5], MPIE[7], SPP[8], MPP[12:11]. All other bits read 0.
- **CSR write addresses:**
  - 0x300 mstatus writes only the implemented bits.
  - 0x341/0x342/0x343 write mepc/mcause/mtval; 0x141/0x142/0x143 write sepc/scause/stval.
  - 0x100 sstatus writes SIE, SPIE and SPP only.
  - Writes to xepc clear bit 0. Other addresses are ignored.
- **Write arbitration:** csr_we is accepted only in IDLE and is dropped while trap_busy. In IDLE with exc_valid, the CSR write and the capture both occur.

## Timing
- **Reset:**
  - State = IDLE, priv_mode = 11.
  - All CSRs = 0; MPP = 00.
  - flush_req = 0, redirect_valid = 0, redirect_pc = 0, trap_busy = 0, flush_timeout = 0.
- **Minimum latency:**
  - exc_valid at T gives flush_req and trap_busy at T+1.
  - flush_ack at T+1 gives COMMIT at T+2, with CSR/priv visible at T+3.
  - redirect_valid is high during T+3 and the block is back in IDLE at T+4.
- **Flush handshake:** flush_req holds until ack is sampled and is deasserted in COMMIT. An ack outside FLUSH is ignored.
- **Reset mid-sequence:** an asynchronous rst_n abandons the sequence immediately, with no partial CSR update beyond what was committed before.
- **Back-to-back traps:** a new exc_valid is accepted in the cycle after REDIRECT. That is 4 cycles per trap minimum.

## Configuration
- TRAP_CTRL_WATCHDOG_EN defined:
  - A counter in FLUSH increments each cycle without ack.
  - When it reaches FLUSH_TIMEOUT, the block proceeds to COMMIT and sets flush_timeout, which stays set until reset.
  - The counter clears on leaving FLUSH.
- TRAP_CTRL_WATCHDOG_EN undefined: FLUSH waits indefinitely and flush_timeout = 0.

## Test plan
- **Illegal instruction in U-mode.** Stimulus: cause=2, pc=0x80, tval=0x00000013, target=11, vector=0x100, ack immediate. Response:
  - mepc=0x80, mcause=2, mtval=0x13.
  - MPP=00, priv=11.
  - redirect_pc=0x100 at T+3.
- **Delegated S-trap then SRET.** Stimulus: ecall from U, target=01, cause=8, pc=0x204, then SRET. Response:
  - sepc=0x204, SPP=0, priv=01.
  - SRET redirects to 0x204 with priv=00 and SIE restored.
- **MRET after CSR writes.** Stimulus: csr write 0x341←0x1003, mstatus MPP=01, MPIE=1, then mret_req. Response:
  - redirect_pc=0x1002, priv=01, MIE=1, MPP=00.
- **Ack delay and masking.** Stimulus: ack withheld 5 cycles, exc_valid re-pulsed during FLUSH. Response:
  - flush_req high for 6 cycles.
  - The second exception is ignored and the first is committed exactly once.
- **Simultaneous events, then reset mid-FLUSH.** Stimulus: exc_valid and mret_req in the same cycle. Response: the trap wins. Stimulus: rst_n low during FLUSH. Response: all outputs return to reset values and priv=11.
- **Watchdog (with TRAP_CTRL_WATCHDOG_EN).** Stimulus: no ack. Response:
  - COMMIT is entered after 15 cycles of FLUSH.
  - flush_timeout=1 and stays set.

Source files
------------

// File: rtl/trap_controller_if.sv
// Trap sequencer handshake bundle: exception/return requests in, flush and redirect out.
// Latency: none, wiring only.
// Backpressure: trap_busy tells the producer to stall; requests presented while busy are dropped.
interface trap_controller_if #(
    parameter int XLEN = 32
);
    logic            exc_valid;
    logic [XLEN-1:0] exc_cause;
    logic [XLEN-1:0] exc_tval;
    logic [XLEN-1:0] exc_pc;
    logic [1:0]      exc_target_priv;
    logic [XLEN-1:0] exc_trap_vector;
    logic            mret_req;
    logic            sret_req;
    logic            flush_req;
    logic            flush_ack;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            trap_busy;

    modport master (
        output exc_valid, exc_cause, exc_tval, exc_pc, exc_target_priv, exc_trap_vector,
        output mret_req, sret_req, flush_ack,
        input  flush_req, redirect_valid, redirect_pc, trap_busy
    );

    modport slave (
        input  exc_valid, exc_cause, exc_tval, exc_pc, exc_target_priv, exc_trap_vector,
        input  mret_req, sret_req, flush_ack,
        output flush_req, redirect_valid, redirect_pc, trap_busy
    );
endinterface

// File: rtl/trap_controller.sv
// Trap entry/return sequencer owning xepc/xcause/xtval, mstatus stack bits and privilege mode.
// Latency: request at T -> flush_req at T+1, CSRs and redirect strobe at T+3 with immediate ack, IDLE at T+4.
// Backpressure: trap_busy while not IDLE; FLUSH waits for flush_ack (bounded when TRAP_CTRL_WATCHDOG_EN is defined).
module trap_controller #(
    parameter int XLEN          = 32,
    parameter int FLUSH_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    trap_controller_if.slave  bus,
    input  logic              csr_we,
    input  logic [11:0]       csr_addr,
    input  logic [XLEN-1:0]   csr_wdata,
    output logic [1:0]        priv_mode,
    output logic [XLEN-1:0]   mepc,
    output logic [XLEN-1:0]   mcause,
    output logic [XLEN-1:0]   mtval,
    output logic [XLEN-1:0]   sepc,
    output logic [XLEN-1:0]   scause,
    output logic [XLEN-1:0]   stval,
    output logic [XLEN-1:0]   mstatus,
    output logic              flush_timeout
);
    typedef enum logic [1:0] {IDLE, FLUSH, COMMIT, REDIRECT} state_t;
    typedef enum logic [1:0] {K_TRAP, K_MRET, K_SRET} kind_t;

    // Exception PCs are always halfword aligned, so bit 0 is forced low on every xepc update.
    localparam logic [XLEN-1:0] EPC_MASK = {{(XLEN-1){1'b1}}, 1'b0};

    state_t          state, next_state;
    kind_t           kind;
    logic [XLEN-1:0] cap_cause, cap_tval, cap_pc, cap_vector;
    logic [1:0]      cap_target;
    logic            sie, mie, spie, mpie, spp;
    logic [1:0]      mpp;
    logic            flush_done;

`ifdef TRAP_CTRL_WATCHDOG_EN
    localparam int WD_W = $clog2(FLUSH_TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            wd_expire;

    // Expiry fires on the last un-acked FLUSH cycle so FLUSH lasts FLUSH_TIMEOUT cycles in total.
    assign wd_expire  = (state == FLUSH) && !bus.flush_ack && (wd_cnt == WD_W'(FLUSH_TIMEOUT - 1));
    assign flush_done = bus.flush_ack || wd_expire;

    // Count un-acked FLUSH cycles, clear on leaving FLUSH; timeout flag is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt        <= '0;
            flush_timeout <= 1'b0;
        end else begin
            if (state == FLUSH && next_state == FLUSH) wd_cnt <= wd_cnt + 1'b1;
            else                                       wd_cnt <= '0;
            if (wd_expire) flush_timeout <= 1'b1;
        end
    end
`else
    // Without the watchdog FLUSH_TIMEOUT has no effect and FLUSH waits for ack forever.
    logic unused_cfg;
    assign unused_cfg    = (FLUSH_TIMEOUT != 0);
    assign flush_done    = bus.flush_ack;
    assign flush_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next state and state-decoded handshake outputs.
    always_comb begin
        next_state         = state;
        bus.flush_req      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.trap_busy      = (state != IDLE);
        case (state)
            IDLE:     if (bus.exc_valid || bus.mret_req || bus.sret_req) next_state = FLUSH;
            FLUSH: begin
                bus.flush_req = 1'b1;
                if (flush_done) next_state = COMMIT;
            end
            COMMIT:   next_state = REDIRECT;
            REDIRECT: begin
                bus.redirect_valid = 1'b1;
                next_state         = IDLE;
            end
            default:  next_state = IDLE;
        endcase
    end

    // Capture the winning request in IDLE; exceptions take priority over MRET over SRET.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kind       <= K_TRAP;
            cap_cause  <= '0;
            cap_tval   <= '0;
            cap_pc     <= '0;
            cap_target <= 2'b00;
            cap_vector <= '0;
        end else if (state == IDLE) begin
            if (bus.exc_valid) begin
                kind       <= K_TRAP;
                cap_cause  <= bus.exc_cause;
                cap_tval   <= bus.exc_tval;
                cap_pc     <= bus.exc_pc;
                cap_target <= bus.exc_target_priv;
                cap_vector <= bus.exc_trap_vector;
            end else if (bus.mret_req) begin
                kind <= K_MRET;
            end else if (bus.sret_req) begin
                kind <= K_SRET;
            end
        end
    end

    // Architectural trap state: software writes in IDLE only, sequencer updates in COMMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            priv_mode       <= 2'b11;
            mepc            <= '0;
            mcause          <= '0;
            mtval           <= '0;
            sepc            <= '0;
            scause          <= '0;
            stval           <= '0;
            {sie, mie, spie, mpie, spp} <= '0;
            mpp             <= 2'b00;
            bus.redirect_pc <= '0;
        end else if (state == IDLE && csr_we) begin
            case (csr_addr)
                12'h300: begin
                    sie  <= csr_wdata[1];
                    mie  <= csr_wdata[3];
                    spie <= csr_wdata[5];
                    mpie <= csr_wdata[7];
                    spp  <= csr_wdata[8];
                    mpp  <= csr_wdata[12:11];
                end
                12'h100: begin
                    sie  <= csr_wdata[1];
                    spie <= csr_wdata[5];
                    spp  <= csr_wdata[8];
                end
                12'h341: mepc   <= csr_wdata & EPC_MASK;
                12'h342: mcause <= csr_wdata;
                12'h343: mtval  <= csr_wdata;
                12'h141: sepc   <= csr_wdata & EPC_MASK;
                12'h142: scause <= csr_wdata;
                12'h143: stval  <= csr_wdata;
                default: ;
            endcase
        end else if (state == COMMIT) begin
            case (kind)
                K_TRAP: begin
                    bus.redirect_pc <= cap_vector;
                    if (cap_target == 2'b01) begin
                        sepc      <= cap_pc & EPC_MASK;
                        scause    <= cap_cause;
                        stval     <= cap_tval;
                        spie      <= sie;
                        sie       <= 1'b0;
                        spp       <= priv_mode[0];
                        priv_mode <= 2'b01;
                    end else begin
                        mepc      <= cap_pc & EPC_MASK;
                        mcause    <= cap_cause;
                        mtval     <= cap_tval;
                        mpie      <= mie;
                        mie       <= 1'b0;
                        mpp       <= priv_mode;
                        priv_mode <= 2'b11;
                    end
                end
                K_MRET: begin
                    bus.redirect_pc <= mepc;
                    mie             <= mpie;
                    mpie            <= 1'b1;
                    priv_mode       <= mpp;
                    mpp             <= 2'b00;
                end
                K_SRET: begin
                    bus.redirect_pc <= sepc;
                    sie             <= spie;
                    spie            <= 1'b1;
                    priv_mode       <= {1'b0, spp};
                    spp             <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // mstatus read view: only the implemented stack bits are non-zero.
    always_comb begin
        mstatus        = '0;
        mstatus[1]     = sie;
        mstatus[3]     = mie;
        mstatus[5]     = spie;
        mstatus[7]     = mpie;
        mstatus[8]     = spp;
        mstatus[12:11] = mpp;
    end
endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: scenario tasks plus a redirect scoreboard.
// Each redirect strobe is matched against the oldest expected target queued at request time.
// Watchdog scenario is selected by TRAP_CTRL_WATCHDOG_EN, matching the design build.
module tb_trap_controller;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [1:0]  priv_mode;
    logic [31:0] mepc, mcause, mtval, sepc, scause, stval, mstatus;
    logic        flush_timeout;

    int          n_checks    = 0;
    int          n_errors    = 0;
    int          n_redirects = 0;
    logic [31:0] exp_q[$];

    trap_controller_if #(.XLEN(32)) bus();

    trap_controller #(.XLEN(32), .FLUSH_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .priv_mode(priv_mode), .mepc(mepc), .mcause(mcause), .mtval(mtval),
        .sepc(sepc), .scause(scause), .stval(stval), .mstatus(mstatus),
        .flush_timeout(flush_timeout)
    );

    always #5 clk = ~clk;

    // Scoreboard: every redirect strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin : sb_mon
        logic [31:0] e;
        if (rst_n && bus.redirect_valid) begin
            n_redirects++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_unexpected: redirect to %h, nothing outstanding", bus.redirect_pc);
            end else begin
                e = exp_q.pop_front();
                if (bus.redirect_pc !== e) begin
                    n_errors++;
                    $display("FAIL sb_redirect_pc: got %h expected %h", bus.redirect_pc, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.exc_valid = 0; bus.exc_cause = 0; bus.exc_tval = 0; bus.exc_pc = 0;
        bus.exc_target_priv = 2'b11; bus.exc_trap_vector = 0;
        bus.mret_req = 0; bus.sret_req = 0; bus.flush_ack = 0;
        csr_we = 0; csr_addr = 0; csr_wdata = 0;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        csr_we = 1; csr_addr = a; csr_wdata = d;
        step();
        csr_we = 0;
    endtask

    task automatic issue_trap(input logic [31:0] cause, input logic [31:0] tval, input logic [31:0] pc,
                              input logic [1:0] tgt, input logic [31:0] vec);
        bus.exc_valid = 1; bus.exc_cause = cause; bus.exc_tval = tval; bus.exc_pc = pc;
        bus.exc_target_priv = tgt; bus.exc_trap_vector = vec;
        exp_q.push_back(vec);
    endtask

    task automatic issue_ret(input bit is_m, input logic [31:0] target);
        if (is_m) bus.mret_req = 1;
        else      bus.sret_req = 1;
        exp_q.push_back(target);
    endtask

    // Runs the flush handshake after a request; ack is given once flush_req has been seen for more than ack_delay cycles.
    task automatic run_seq(input int ack_delay, input bit mask_test, input int budget,
                           output bit got, output int cyc, output int fl_cnt, output bit busy1);
        got = 0; cyc = 0; fl_cnt = 0; busy1 = 0;
        for (int k = 1; k <= budget; k++) begin
            step();
            if (k == 1) begin
                bus.exc_valid = 0; bus.mret_req = 0; bus.sret_req = 0;
                busy1 = bus.trap_busy;
            end
            if (bus.flush_req) begin
                fl_cnt++;
                bus.flush_ack = (fl_cnt > ack_delay);
                if (mask_test && fl_cnt == 2) begin
                    bus.exc_valid = 1; bus.exc_cause = 32'hBAD; bus.exc_pc = 32'hBAD0;
                    bus.exc_trap_vector = 32'h900; bus.mret_req = 1;
                    csr_we = 1; csr_addr = 12'h343; csr_wdata = 32'hDEAD;
                end else if (mask_test && fl_cnt == 3) begin
                    bus.exc_valid = 0; bus.mret_req = 0; csr_we = 0;
                end
            end else begin
                bus.flush_ack = 0;
            end
            if (bus.redirect_valid) begin
                got = 1;
                cyc = k;
                break;
            end
        end
        bus.flush_ack = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        repeat (3) step();
        rst_n = 1;
        step();
        n_checks++; if (priv_mode !== 2'b11) begin n_errors++; $display("FAIL reset_priv: got %b expected 11", priv_mode); end
        n_checks++; if (mstatus !== 32'h0) begin n_errors++; $display("FAIL reset_mstatus: got %h expected 0", mstatus); end
        n_checks++; if ({mepc, mcause, mtval} !== 96'h0) begin n_errors++; $display("FAIL reset_mcsrs: got %h %h %h expected 0", mepc, mcause, mtval); end
        n_checks++; if ({sepc, scause, stval} !== 96'h0) begin n_errors++; $display("FAIL reset_scsrs: got %h %h %h expected 0", sepc, scause, stval); end
        n_checks++; if ({bus.flush_req, bus.redirect_valid, bus.trap_busy, flush_timeout} !== 4'b0) begin n_errors++; $display("FAIL reset_ctrl: got %b expected 0000", {bus.flush_req, bus.redirect_valid, bus.trap_busy, flush_timeout}); end
        n_checks++; if (bus.redirect_pc !== 32'h0) begin n_errors++; $display("FAIL reset_redirect_pc: got %h expected 0", bus.redirect_pc); end
    endtask

    task automatic test_illegal_u();
        bit got, b1; int cyc, fl;
        csr_write(12'h300, 32'h80);
        n_checks++; if (mstatus !== 32'h80) begin n_errors++; $display("FAIL ill_mstatus_wr: got %h expected 00000080", mstatus); end
        issue_ret(1, 32'h0);
        run_seq(0, 0, 20, got, cyc, fl, b1);
        step();
        n_checks++; if (priv_mode !== 2'b00 || mstatus !== 32'h88) begin n_errors++; $display("FAIL ill_enter_u: got priv %b mstatus %h expected 00 / 00000088", priv_mode, mstatus); end
        issue_trap(32'd2, 32'h13, 32'h80, 2'b11, 32'h100);
        run_seq(0, 0, 20, got, cyc, fl, b1);
        n_checks++; if (!got || cyc != 3 || fl != 1 || !b1) begin n_errors++; $display("FAIL ill_latency: got redirect %0d at cycle %0d flush %0d busy1 %0d expected 1 / 3 / 1 / 1", got, cyc, fl, b1); end
        n_checks++; if (bus.redirect_pc !== 32'h100) begin n_errors++; $display("FAIL ill_redirect_pc: got %h expected 00000100", bus.redirect_pc); end
        n_checks++; if ({mepc, mcause, mtval} !== {32'h80, 32'd2, 32'h13}) begin n_errors++; $display("FAIL ill_mcsrs: got %h %h %h expected 80 2 13", mepc, mcause, mtval); end
        n_checks++; if (priv_mode !== 2'b11 || mstatus !== 32'h80) begin n_errors++; $display("FAIL ill_priv: got priv %b mstatus %h expected 11 / 00000080", priv_mode, mstatus); end
        step();
        n_checks++; if (bus.trap_busy !== 1'b0 || bus.redirect_valid !== 1'b0) begin n_errors++; $display("FAIL ill_back_idle: got busy %b redirect %b expected 0 0", bus.trap_busy, bus.redirect_valid); end
    endtask

    task automatic test_s_trap_sret();
        bit got, b1; int cyc, fl;
        csr_write(12'h300, 32'h0);
        csr_write(12'h100, 32'h2);
        n_checks++; if (mstatus !== 32'h2) begin n_errors++; $display("FAIL s_sstatus_wr: got %h expected 00000002", mstatus); end
        issue_ret(1, 32'h80);
        run_seq(0, 0, 20, got, cyc, fl, b1);
        step();
        n_checks++; if (priv_mode !== 2'b00 || mstatus !== 32'h82) begin n_errors++; $display("FAIL s_enter_u: got priv %b mstatus %h expected 00 / 00000082", priv_mode, mstatus); end
        issue_trap(32'd8, 32'h0, 32'h204, 2'b01, 32'h400);
        run_seq(0, 0, 20, got, cyc, fl, b1);
        n_checks++; if (!got || cyc != 3) begin n_errors++; $display("FAIL s_latency: got redirect %0d at cycle %0d expected 1 / 3", got, cyc); end
        n_checks++; if ({sepc, scause, stval} !== {32'h204, 32'd8, 32'h0}) begin n_errors++; $display("FAIL s_scsrs: got %h %h %h expected 204 8 0", sepc, scause, stval); end
        n_checks++; if (priv_mode !== 2'b01 || mstatus !== 32'hA0 || mepc !== 32'h80) begin n_errors++; $display("FAIL s_state: got priv %b mstatus %h mepc %h expected 01 / 000000a0 / 80", priv_mode, mstatus, mepc); end
        step();
        issue_ret(0, 32'h204);
        run_seq(0, 0, 20, got, cyc, fl, b1);
        n_checks++; if (!got || bus.redirect_pc !== 32'h204) begin n_errors++; $display("FAIL sret_redirect: got %0d pc %h expected 1 / 00000204", got, bus.redirect_pc); end
        n_checks++; if (priv_mode !== 2'b00 || mstatus !== 32'hA2) begin n_errors++; $display("FAIL sret_state: got priv %b mstatus %h expected 00 / 000000a2", priv_mode, mstatus); end
        step();
    endtask

    task automatic test_mret_csr();
        bit got, b1; int cyc, fl;
        csr_write(12'h341, 32'h1003);
        n_checks++; if (mepc !== 32'h1002) begin n_errors++; $display("FAIL mret_mepc_wr: got %h expected 00001002", mepc); end
        csr_write(12'h300, 32'h0001_0880);
        n_checks++; if (mstatus !== 32'h880) begin n_errors++; $display("FAIL mret_mstatus_wr: got %h expected 00000880", mstatus); end
        issue_ret(1, 32'h1002);
        run_seq(0, 0, 20, got, cyc, fl, b1);
        n_checks++; if (!got || cyc != 3 || bus.redirect_pc !== 32'h1002) begin n_errors++; $display("FAIL mret_redirect: got %0d cycle %0d pc %h expected 1 / 3 / 00001002", got, cyc, bus.redirect_pc); end
        n_checks++; if (priv_mode !== 2'b01 || mstatus !== 32'h88) begin n_errors++; $display("FAIL mret_state: got priv %b mstatus %h expected 01 / 00000088", priv_mode, mstatus); end
        step();
    endtask

    task automatic test_ack_delay_mask();
        bit got, b1, busy_seen; int cyc, fl, r0;
        r0 = n_redirects;
        issue_trap(32'd5, 32'h55, 32'h301, 2'b11, 32'h800);
        run_seq(5, 1, 30, got, cyc, fl, b1);
        n_checks++; if (!got || fl != 6 || cyc != 8) begin n_errors++; $display("FAIL ack_delay: got redirect %0d flush cycles %0d at cycle %0d expected 1 / 6 / 8", got, fl, cyc); end
        n_checks++; if ({mepc, mcause, mtval} !== {32'h300, 32'd5, 32'h55}) begin n_errors++; $display("FAIL ack_mcsrs: got %h %h %h expected 300 5 55", mepc, mcause, mtval); end
        n_checks++; if (priv_mode !== 2'b11 || mstatus !== 32'h880) begin n_errors++; $display("FAIL ack_state: got priv %b mstatus %h expected 11 / 00000880", priv_mode, mstatus); end
        busy_seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.trap_busy) busy_seen = 1;
        end
        n_checks++; if (busy_seen || n_redirects != r0 + 1) begin n_errors++; $display("FAIL ack_once: got busy %0d redirects %0d expected 0 / %0d", busy_seen, n_redirects - r0, 1); end
    endtask

    task automatic test_back_to_back();
        bit got, b1; int cyc, fl;
        issue_trap(32'd1, 32'h0, 32'h10, 2'b11, 32'h1000);
        run_seq(0, 0, 20, got, cyc, fl, b1);
        n_checks++; if (!got || cyc != 3 || mcause !== 32'd1) begin n_errors++; $display("FAIL b2b_first: got %0d cycle %0d mcause %h expected 1 / 3 / 1", got, cyc, mcause); end
        step();
        issue_trap(32'd3, 32'h0, 32'h20, 2'b11, 32'h2000);
        run_seq(0, 0, 20, got, cyc, fl, b1);
        n_checks++; if (!got || cyc != 3 || mcause !== 32'd3 || mepc !== 32'h20) begin n_errors++; $display("FAIL b2b_second: got %0d cycle %0d mcause %h mepc %h expected 1 / 3 / 3 / 20", got, cyc, mcause, mepc); end
        step();
    endtask

    task automatic test_simultaneous_reset();
        bit got, b1; int cyc, fl;
        issue_trap(32'd7, 32'h0, 32'h44, 2'b11, 32'h3000);
        bus.mret_req = 1;
        run_seq(0, 0, 20, got, cyc, fl, b1);
        n_checks++; if (!got || mcause !== 32'd7 || mepc !== 32'h44) begin n_errors++; $display("FAIL simul_trap_wins: got %0d mcause %h mepc %h expected 1 / 7 / 44", got, mcause, mepc); end
        step();
        step();
        n_checks++; if (bus.trap_busy !== 1'b0) begin n_errors++; $display("FAIL simul_mret_dropped: got busy %b expected 0", bus.trap_busy); end
        issue_trap(32'd9, 32'h0, 32'h88, 2'b01, 32'h5000);
        step();
        bus.exc_valid = 0;
        n_checks++; if (bus.flush_req !== 1'b1) begin n_errors++; $display("FAIL rst_in_flush: got flush_req %b expected 1", bus.flush_req); end
        #2;
        rst_n = 0;
        exp_q.delete();
        #1;
        n_checks++; if (priv_mode !== 2'b11 || mstatus !== 32'h0) begin n_errors++; $display("FAIL rst_mid_priv: got priv %b mstatus %h expected 11 / 0", priv_mode, mstatus); end
        n_checks++; if ({mepc, mcause, sepc, scause} !== 128'h0) begin n_errors++; $display("FAIL rst_mid_csrs: got %h %h %h %h expected 0", mepc, mcause, sepc, scause); end
        n_checks++; if ({bus.flush_req, bus.redirect_valid, bus.trap_busy, flush_timeout} !== 4'b0 || bus.redirect_pc !== 32'h0) begin n_errors++; $display("FAIL rst_mid_ctrl: got %b pc %h expected 0000 / 0", {bus.flush_req, bus.redirect_valid, bus.trap_busy, flush_timeout}, bus.redirect_pc); end
        step();
        rst_n = 1;
        repeat (5) step();
        n_checks++; if (bus.trap_busy !== 1'b0 || sepc !== 32'h0) begin n_errors++; $display("FAIL rst_mid_after: got busy %b sepc %h expected 0 / 0", bus.trap_busy, sepc); end
    endtask

    task automatic test_watchdog();
        bit got, b1; int cyc, fl;
        issue_trap(32'hB, 32'h0, 32'h600, 2'b11, 32'h700);
`ifdef TRAP_CTRL_WATCHDOG_EN
        run_seq(1000, 0, 40, got, cyc, fl, b1);
        n_checks++; if (!got || fl != 15 || cyc != 17) begin n_errors++; $display("FAIL wd_expire: got %0d flush cycles %0d at cycle %0d expected 1 / 15 / 17", got, fl, cyc); end
        n_checks++; if (flush_timeout !== 1'b1 || mcause !== 32'hB) begin n_errors++; $display("FAIL wd_flag: got %b mcause %h expected 1 / b", flush_timeout, mcause); end
        step();
        issue_trap(32'hC, 32'h0, 32'h610, 2'b11, 32'h710);
        run_seq(0, 0, 20, got, cyc, fl, b1);
        n_checks++; if (!got || flush_timeout !== 1'b1) begin n_errors++; $display("FAIL wd_sticky: got %0d flag %b expected 1 / 1", got, flush_timeout); end
`else
        run_seq(1000, 0, 40, got, cyc, fl, b1);
        n_checks++; if (got || bus.flush_req !== 1'b1 || flush_timeout !== 1'b0) begin n_errors++; $display("FAIL nowd_wait: got redirect %0d flush_req %b flag %b expected 0 / 1 / 0", got, bus.flush_req, flush_timeout); end
        run_seq(0, 0, 10, got, cyc, fl, b1);
        n_checks++; if (!got || mcause !== 32'hB || flush_timeout !== 1'b0) begin n_errors++; $display("FAIL nowd_ack: got %0d mcause %h flag %b expected 1 / b / 0", got, mcause, flush_timeout); end
`endif
        step();
    endtask

    initial begin
        test_reset();
        test_illegal_u();
        test_s_trap_sret();
        test_mret_csr();
        test_ack_delay_mask();
        test_back_to_back();
        test_simultaneous_reset();
        test_watchdog();
        repeat (2) step();
        n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL sb_drain: got %0d outstanding redirects expected 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
